// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch front end. Issues word-aligned fetch requests to
// instruction memory, places the returned words with their addresses in a
// small in-order queue, and presents the queue head to the decoder. A
// redirect (branch/jump/trap) flushes the queue and restarts fetch at a new
// address. If a request is still in flight when the redirect arrives, the
// returning data is thrown away before fetch restarts.
//
// Parameters
//   RESET_PC     first fetch address after reset (word aligned)
//   QDEPTH       instruction queue entries, 2..4
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request, held until acknowledged
//   imem_addr    fetch address, held while imem_req is high
//   imem_ack     completes the request; imem_rdata valid in the same cycle
//   imem_rdata   fetched instruction word
//   redirect     one-cycle pulse requesting a PC change
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   inst_valid   queue head holds an instruction
//   inst_ready   decoder accepts the queue head
//   inst_out     queue head instruction
//   inst_pc      address of inst_out
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch; acked data is pushed into the queue
// DRAIN | a request issued before a redirect is still in flight; its data
//       | is dropped on ack and fetch resumes at the latched target
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc
);

   localparam int            PW          = (QDEPTH > 2) ? 2 : 1;
   localparam logic [2:0]    QDEPTH_C    = 3'(QDEPTH);
   localparam logic [PW-1:0] PTR_LAST    = PW'(QDEPTH - 1);
   localparam logic [31:0]   RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   target_pc;
   logic          req_q;

   logic [31:0]   q_data [QDEPTH];
   logic [31:0]   q_pc   [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [2:0]    count;

   logic          ack_fire;
   logic          pending;
   logic          push;
   logic          pop;
   logic [2:0]    count_nxt;
   logic          req_nxt;
   logic [31:0]   redirect_al;
   logic          unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign redirect_al = {redirect_pc[31:2], 2'b00};
   assign unused_bits = ^redirect_pc[1:0];

   assign ack_fire = req_q & imem_ack;
   // request survives this edge un-acked; it keeps its address and slot
   assign pending  = req_q & ~imem_ack;
   // a redirect on the ack edge wins over the push: the data is stale
   assign push     = (state == RUN) & ack_fire & ~redirect;
   assign pop      = inst_valid & inst_ready;

   always_comb begin
      count_nxt = count;
      if (redirect) begin
         count_nxt = 3'd0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt = count + 3'd1;
            2'b01:   count_nxt = count - 3'd1;
            default: count_nxt = count;
         endcase
      end
   end

   // A fresh request only starts once the previous one has completed and
   // there is a free queue slot to receive its data.
   assign req_nxt = pending | (count_nxt < QDEPTH_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         fetch_pc  <= RESET_PC_AL;
         target_pc <= RESET_PC_AL;
         req_q     <= 1'b0;
         head      <= '0;
         tail      <= '0;
         count     <= 3'd0;
      end else begin
         req_q <= req_nxt;
         count <= count_nxt;

         if (redirect) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
         end

         case (state)
            RUN: begin
               if (redirect) begin
                  if (pending) begin
                     // imem_addr must stay put until the ack, so park the target
                     target_pc <= redirect_al;
                     state     <= DRAIN;
                  end else begin
                     fetch_pc <= redirect_al;
                  end
               end else if (ack_fire) begin
                  fetch_pc <= fetch_pc + 32'd4;
               end
            end
            DRAIN: begin
               if (redirect) target_pc <= redirect_al;
               if (ack_fire) begin
                  fetch_pc <= redirect ? redirect_al : target_pc;
                  state    <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // queue storage carries no control meaning, so it is left unreset
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[tail] <= imem_rdata;
         q_pc[tail]   <= fetch_pc;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != 3'd0);
   assign inst_out   = inst_valid ? q_data[head] : 32'd0;
   assign inst_pc    = inst_valid ? q_pc[head]   : 32'd0;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   localparam logic [31:0] MAGIC = 32'hC0DE_0000;
   localparam int          NVEC  = 19;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        rst;
      logic        ack;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        e_zero;
   } vec_t;

   vec_t vt [NVEC];

   fetch_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: each word is a known function of its address
   always_comb imem_rdata = imem_addr ^ MAGIC;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic rst, input logic ack, input logic redir,
                               input logic [31:0] rpc, input logic rdy,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc,
                               input logic e_zero);
      vec_t v;
      v.rst = rst; v.ack = ack; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      v.e_zero = e_zero;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic rst, input logic ack, input logic redir,
                        input logic [31:0] rpc, input logic rdy);
      rst_n       = rst;
      imem_ack    = ack;
      redirect    = redir;
      redirect_pc = rpc;
      inst_ready  = rdy;
   endtask

   initial begin
      logic found;
      logic bad;

      //                rst ack red rpc            rdy  req addr           vld pc             zero
      vt[0]  = mk(1, 1, 0, 32'h0,          1,   0, 32'h0000_0000, 0, 32'h0,          1);
      vt[1]  = mk(1, 1, 0, 32'h0,          1,   1, 32'h0000_0000, 0, 32'h0,          0);
      vt[2]  = mk(1, 1, 0, 32'h0,          1,   1, 32'h0000_0004, 1, 32'h0000_0000, 0);
      vt[3]  = mk(1, 1, 0, 32'h0,          1,   1, 32'h0000_0008, 1, 32'h0000_0004, 0);
      vt[4]  = mk(1, 1, 0, 32'h0,          0,   1, 32'h0000_000C, 1, 32'h0000_0008, 0);
      vt[5]  = mk(1, 1, 0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_0008, 0);
      vt[6]  = mk(1, 1, 1, 32'h0000_0103,  1,   0, 32'h0000_0010, 1, 32'h0000_0008, 0);
      vt[7]  = mk(1, 1, 0, 32'h0,          1,   1, 32'h0000_0100, 0, 32'h0,          0);
      vt[8]  = mk(0, 1, 0, 32'h0,          0,   1, 32'h0000_0104, 1, 32'h0000_0100, 0);
      vt[9]  = mk(1, 1, 0, 32'h0,          0,   0, 32'h0000_0000, 0, 32'h0,          1);
      vt[10] = mk(1, 1, 0, 32'h0,          0,   1, 32'h0000_0000, 0, 32'h0,          0);
      vt[11] = mk(1, 1, 0, 32'h0,          0,   1, 32'h0000_0004, 1, 32'h0000_0000, 0);
      vt[12] = mk(1, 1, 0, 32'h0,          0,   0, 32'h0000_0008, 1, 32'h0000_0000, 0);
      vt[13] = mk(1, 1, 0, 32'h0,          1,   0, 32'h0000_0008, 1, 32'h0000_0000, 0);
      vt[14] = mk(1, 1, 0, 32'h0,          1,   1, 32'h0000_0008, 1, 32'h0000_0004, 0);
      vt[15] = mk(1, 1, 1, 32'hFFFF_FFFF,  1,   1, 32'h0000_000C, 1, 32'h0000_0008, 0);
      vt[16] = mk(1, 1, 0, 32'h0,          1,   1, 32'hFFFF_FFFC, 0, 32'h0,          0);
      vt[17] = mk(1, 0, 0, 32'h0,          0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);
      vt[18] = mk(1, 0, 0, 32'h0,          0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);

      drive(0, 0, 0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);

      // ---------------- table-driven section ----------------
      for (int i = 0; i < NVEC; i++) begin
         chk($sformatf("r%0d_req", i),   {31'd0, imem_req},   {31'd0, vt[i].e_req});
         chk($sformatf("r%0d_addr", i),  imem_addr,           vt[i].e_addr);
         chk($sformatf("r%0d_valid", i), {31'd0, inst_valid}, {31'd0, vt[i].e_valid});
         if (vt[i].e_valid) begin
            chk($sformatf("r%0d_pc", i),  inst_pc,  vt[i].e_pc);
            chk($sformatf("r%0d_out", i), inst_out, vt[i].e_pc ^ MAGIC);
         end else if (vt[i].e_zero) begin
            chk($sformatf("r%0d_pc_rst", i),  inst_pc,  32'h0);
            chk($sformatf("r%0d_out_rst", i), inst_out, 32'h0);
         end
         drive(vt[i].rst, vt[i].ack, vt[i].redir, vt[i].rpc, vt[i].rdy);
         tick();
      end

      // ---------------- redirects during a delayed ack ----------------
      drive(0, 0, 0, 32'h0, 0);
      tick();
      drive(1, 1, 0, 32'h0, 1);
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (imem_req && imem_addr == 32'h8) begin
            found = 1'b1;
            break;
         end
      end
      chk("drain_reach_8", {31'd0, found}, 32'd1);
      drive(1, 0, 0, 32'h0, 1);
      tick();
      chk("drain_hold1_addr", imem_addr, 32'h8);
      chk("drain_hold1_req", {31'd0, imem_req}, 32'd1);
      drive(1, 0, 1, 32'h200, 1);
      tick();
      chk("drain_hold2_addr", imem_addr, 32'h8);
      chk("drain_hold2_valid", {31'd0, inst_valid}, 32'd0);
      drive(1, 0, 1, 32'h300, 1);
      tick();
      chk("drain_hold3_addr", imem_addr, 32'h8);
      chk("drain_hold3_req", {31'd0, imem_req}, 32'd1);
      drive(1, 1, 0, 32'h0, 1);
      tick();
      chk("drain_next_req", {31'd0, imem_req}, 32'd1);
      chk("drain_next_addr", imem_addr, 32'h300);
      chk("drain_no_stale", {31'd0, inst_valid}, 32'd0);
      tick();
      chk("drain_first_valid", {31'd0, inst_valid}, 32'd1);
      chk("drain_first_pc", inst_pc, 32'h300);
      chk("drain_first_out", inst_out, 32'h300 ^ MAGIC);
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (imem_req && imem_addr == 32'h200) bad = 1'b1;
         if (inst_valid && (inst_pc == 32'h200 || inst_pc == 32'h8)) bad = 1'b1;
      end
      chk("drain_never_200", {31'd0, bad}, 32'd0);

      // ---------------- reset during an outstanding request ----------------
      drive(0, 0, 0, 32'h0, 0);
      tick();
      drive(1, 1, 0, 32'h0, 0);
      tick();
      tick();
      drive(1, 0, 0, 32'h0, 0);
      tick();
      chk("mrst_pre_req", {31'd0, imem_req}, 32'd1);
      chk("mrst_pre_valid", {31'd0, inst_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_req", {31'd0, imem_req}, 32'd0);
      chk("mrst_valid", {31'd0, inst_valid}, 32'd0);
      chk("mrst_addr", imem_addr, 32'h0);
      @(negedge clk);
      drive(1, 1, 0, 32'h0, 1);
      tick();
      chk("mrst_restart_req", {31'd0, imem_req}, 32'd1);
      chk("mrst_restart_addr", imem_addr, 32'h0);
      tick();
      chk("mrst_restart_pc", inst_pc, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset (bits[1:0] must be 0).
REQ-002 SHALL have parameter QDEPTH, default 2, the number of instruction-queue entries (legal values 2..4).
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port imem_req, output, 1, the fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, 32, the fetch address; always word-aligned.
REQ-007 SHALL have port imem_ack, input, 1, which completes the request; the data in imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-009 SHALL have port redirect, input, 1, a one-cycle pulse that requests a PC change (branch/jump/trap).
REQ-010 SHALL have port redirect_pc, input, 32, the new fetch address; only bits[31:2] are used.
REQ-011 SHALL have port inst_valid, output, 1, asserted when the queue head holds an instruction.
REQ-012 SHALL have port inst_ready, input, 1, asserted when the decoder accepts the queue head.
REQ-013 SHALL have port inst_out, output, 32, the queue-head instruction.
REQ-014 SHALL have port inst_pc, output, 32, the address of inst_out.

Function
REQ-015 SHALL complete a memory transaction on any rising edge where imem_req=1 and imem_ack=1; at most one transaction SHALL be outstanding.
REQ-016 SHALL hold imem_req high, with imem_addr unchanged, from assertion until the acknowledging edge.
REQ-017 SHALL start a new request only if (queue count + outstanding) < QDEPTH; with immediate ack, this gives back-to-back requests of one per cycle.
REQ-018 SHALL use the FSM states RUN (no flush pending) and DRAIN (an outstanding request whose data must be discarded).
REQ-019 In RUN, an ack with no redirect SHALL push {fetch_pc, imem_rdata} into the queue and set fetch_pc <= fetch_pc + 4, mod 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-020 SHALL pop the queue head on any edge where inst_valid=1 and inst_ready=1; a push and a pop in the same cycle SHALL both take effect and leave the count unchanged.
REQ-021 A redirect in RUN with no outstanding request, or with an ack on the same edge, SHALL flush all queue entries, discard any acked data, set fetch_pc <= {redirect_pc[31:2], 2'b00}, and stay in RUN.
REQ-022 A redirect in RUN with an outstanding, un-acked request SHALL flush the queue, latch the new target, and enter DRAIN; imem_addr SHALL stay unchanged.
REQ-023 In DRAIN, an ack SHALL discard imem_rdata, load fetch_pc from the latched target, and enter RUN; the new request SHALL issue on the following cycle.
REQ-024 A redirect while in DRAIN SHALL overwrite the latched target; the last redirect wins.
REQ-025 A pop in the same cycle as a redirect SHALL count as consumed; redirect has priority over a push on that edge.
REQ-026 inst_valid SHALL be 0 in the cycle after a flush and SHALL never present a pre-redirect instruction after the redirect edge.
REQ-027 With a full queue and inst_ready=0, the block SHALL keep imem_req=0 and all outputs stable.

Reset
REQ-028 While rst_n=0, outputs SHALL be: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0; state RUN; queue empty; fetch_pc=RESET_PC.
REQ-029 Asserting reset mid-transaction SHALL abandon the transaction immediately, with no ack expected.
REQ-030 imem_req SHALL assert at the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset release, ack tied high, inst_ready=1 -> imem_addr sequence 0,4,8,...; inst_pc/inst_out follow one cycle later with one instruction per cycle.
REQ-032 inst_ready=0, QDEPTH=2 -> exactly 2 acks accepted (pc 0,4), then imem_req=0; raise inst_ready -> pops pc 0 then 4, and fetching resumes at 8.
REQ-033 Redirect to 32'h100 with no request outstanding -> queue empties, next imem_addr=32'h100, first inst_pc after that is 32'h100.
REQ-034 Request at 32'h8 with ack delayed 3 cycles, redirect to 32'h200 in the delay, then redirect to 32'h300 -> the data for 32'h8 is discarded, the next request is 32'h300, and 32'h200 is never fetched.
REQ-035 redirect_pc=32'h0000_0103 -> fetch at 32'h100; fetch_pc 32'hFFFF_FFFC -> next address 32'h0.
REQ-036 rst_n pulsed low during an outstanding request -> imem_req=0 and inst_valid=0 immediately, and fetch restarts at RESET_PC.
